// File: rtl/bn_unpack_mux_pipe.sv
// Bank-select and word-unpack operand mux feeding a radix-(MEM_NUM*PACK) butterfly.
// Two-stage valid/ready pipeline with frame beat counting and a sticky illegal-select flag.
module bn_unpack_mux_pipe #(
   parameter  int unsigned P_WIDTH   = 64,
   parameter  int unsigned PACK      = 2,
   parameter  int unsigned MEM_NUM   = 8,
   parameter  int unsigned BN_NUM    = 2,
   parameter  int unsigned FRAME_LEN = 1024,
   localparam int unsigned SD_WIDTH  = P_WIDTH * PACK,
   localparam int unsigned SEL_W     = (BN_NUM > 1) ? $clog2(BN_NUM) : 1,
   localparam int unsigned CNT_W     = $clog2(FRAME_LEN),
   localparam int unsigned RADIX     = MEM_NUM * PACK
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [BN_NUM*MEM_NUM*SD_WIDTH-1:0]   bn_mem_in,
   input  logic [SEL_W-1:0]                     bn_sel,
   input  logic                                 seg_lsb_first,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic [RADIX*P_WIDTH-1:0]             ra_out,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 out_last,
   output logic [CNT_W-1:0]                     beat_cnt,
   output logic                                 sel_err
);

   localparam int unsigned BANK_W = MEM_NUM * SD_WIDTH;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

   logic                     s1_valid;
   logic                     s1_lsb;
   logic                     s1_zero;
   logic [BANK_W-1:0]        s1_words;
   logic [BANK_W-1:0]        sel_words;
   logic [RADIX*P_WIDTH-1:0] lanes;
   logic                     sel_bad;
   logic                     s1_adv;
   logic                     s2_adv;
   logic                     accept;
   logic                     out_fire;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv && !rst;
   assign accept   = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign sel_bad  = 32'(bn_sel) >= BN_NUM;
   assign out_last = out_valid && (beat_cnt == LAST_BEAT);

   // Out-of-range selects match no bank and therefore present an all-zero word set.
   always_comb begin
      sel_words = '0;
      for (int unsigned b = 0; b < BN_NUM; b++) begin
         if (bn_sel == SEL_W'(b)) begin
            sel_words = bn_mem_in[b*BANK_W +: BANK_W];
         end
      end
   end

   always_comb begin
      lanes = '0;
      if (!s1_zero) begin
         for (int unsigned m = 0; m < MEM_NUM; m++) begin
            for (int unsigned k = 0; k < PACK; k++) begin
               if (s1_lsb) begin
                  lanes[(m*PACK+k)*P_WIDTH +: P_WIDTH] =
                     s1_words[m*SD_WIDTH + k*P_WIDTH +: P_WIDTH];
               end else begin
                  lanes[(m*PACK+k)*P_WIDTH +: P_WIDTH] =
                     s1_words[m*SD_WIDTH + (PACK-1-k)*P_WIDTH +: P_WIDTH];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_lsb    <= 1'b0;
         s1_zero   <= 1'b0;
         s1_words  <= '0;
         out_valid <= 1'b0;
         ra_out    <= '0;
         beat_cnt  <= '0;
         sel_err   <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= accept;
         end
         if (accept) begin
            s1_words <= sel_words;
            s1_lsb   <= seg_lsb_first;
            s1_zero  <= sel_bad;
            if (sel_bad) begin
               sel_err <= 1'b1;
            end
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               ra_out <= lanes;
            end
         end
         if (out_fire) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bn_unpack_mux_pipe.sv
// Bench for bn_unpack_mux_pipe: directed vector table, multi-cycle sequences and
// randomized traffic checked by a queue-based reference model.
module tb_bn_unpack_mux_pipe;

   localparam int unsigned PW    = 64;
   localparam int unsigned PK    = 2;
   localparam int unsigned MN    = 8;
   localparam int unsigned BN    = 3;
   localparam int unsigned FL    = 4;
   localparam int unsigned SDW   = PW * PK;
   localparam int unsigned RADIX = MN * PK;
   localparam int unsigned MEMW  = BN * MN * SDW;
   localparam int unsigned LW    = RADIX * PW;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [MEMW-1:0] bn_mem_in = '0;
   logic [1:0]      bn_sel = '0;
   logic            seg_lsb_first = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [LW-1:0]   ra_out;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic            out_last;
   logic [1:0]      beat_cnt;
   logic            sel_err;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   bn_unpack_mux_pipe #(
      .P_WIDTH  (PW),
      .PACK     (PK),
      .MEM_NUM  (MN),
      .BN_NUM   (BN),
      .FRAME_LEN(FL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bn_mem_in    (bn_mem_in),
      .bn_sel       (bn_sel),
      .seg_lsb_first(seg_lsb_first),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .ra_out       (ra_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_last     (out_last),
      .beat_cnt     (beat_cnt),
      .sel_err      (sel_err)
   );

   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_lanes(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         for (int i = 0; i < RADIX; i++) begin
            if (act[i*PW +: PW] !== exp[i*PW +: PW]) begin
               $display("FAIL %s: lane %0d got %h expected %h", name, i,
                        act[i*PW +: PW], exp[i*PW +: PW]);
               break;
            end
         end
      end
   endtask

   // Reference unpack: pick bank words by shifting the flat bus, split by shifting the word.
   function automatic logic [LW-1:0] model_lanes(input logic [1:0] sel, input logic lsb,
                                                  input logic [MEMW-1:0] mem);
      logic [LW-1:0]  r;
      logic [SDW-1:0] w;
      r = '0;
      if (int'(sel) >= int'(BN)) return r;
      for (int m = 0; m < int'(MN); m++) begin
         w = SDW'(mem >> ((int'(sel) * int'(MN) + m) * int'(SDW)));
         for (int k = 0; k < int'(PK); k++) begin
            if (lsb) r[(m*PK+k)*PW +: PW] = PW'(w >> (k * PW));
            else     r[(m*PK+k)*PW +: PW] = PW'(w >> ((int'(PK) - 1 - k) * PW));
         end
      end
      return r;
   endfunction

   // ---------------- scoreboard ----------------
   logic [LW-1:0] exp_q[$];
   int unsigned   m_cnt = 0;
   logic          m_err = 1'b0;
   logic          hold_chk = 1'b0;
   logic [LW-1:0] held;
   int unsigned   n_last = 0;
   int unsigned   n_hs = 0;
   logic [1:0]    cnt_log[$];
   logic          last_log[$];

   always @(negedge clk) begin
      if (rst) begin
         chk("in_ready_in_rst", 64'(in_ready), 64'd0);
         exp_q.delete();
         m_cnt = 0;
         m_err = 1'b0;
         hold_chk = 1'b0;
      end else begin
         chk("in_ready", 64'(in_ready), 64'(!(exp_q.size() >= 2 && !out_ready)));
         chk("sel_err", 64'(sel_err), 64'(m_err));
         chk("beat_cnt", 64'(beat_cnt), 64'(m_cnt));
         chk("out_last", 64'(out_last), 64'(out_valid && m_cnt == FL - 1));
         if (hold_chk) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk_lanes("hold_data", ra_out, held);
         end
         hold_chk = out_valid && !out_ready;
         held = ra_out;
         if (out_valid && out_ready) begin
            n_hs++;
            cnt_log.push_back(beat_cnt);
            last_log.push_back(out_last);
            if (out_last) n_last++;
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'd1, 64'd0);
            end else begin
               chk_lanes("beat_data", ra_out, exp_q.pop_front());
            end
            m_cnt = (m_cnt + 1) % FL;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model_lanes(bn_sel, seg_lsb_first, bn_mem_in));
            if (int'(bn_sel) >= int'(BN)) m_err = 1'b1;
         end
      end
   end

   // ---------------- out_ready driver ----------------
   int unsigned or_mode = 0;
   int unsigned cyc = 0;
   always @(posedge clk) begin
      #1;
      cyc++;
      case (or_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'b0;
         2: out_ready = (cyc % 3 == 0);
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // ---------------- stimulus tasks ----------------
   task automatic set_word(input int b, input int m, input logic [SDW-1:0] w);
      bn_mem_in[(b*MN+m)*SDW +: SDW] = w;
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < int'(BN * MN); i++)
         bn_mem_in[i*SDW +: SDW] = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic send(input logic [1:0] sel, input logic lsb);
      logic acc;
      int   n;
      n = 0;
      acc = 1'b0;
      bn_sel = sel;
      seg_lsb_first = lsb;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      or_mode = 0;
      in_valid = 1'b0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic        lsb;
      logic [63:0] e6;
      logic [63:0] e7;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{2'd1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
      tbl[1] = '{2'd0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
      tbl[2] = '{2'd1, 1'b1, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA};
      tbl[3] = '{2'd2, 1'b1, 64'hCAFE_F00D_0000_0002, 64'hDEAD_BEEF_0000_0001};
      tbl[4] = '{2'd0, 1'b1, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};

      randomize_mem();
      set_word(0, 3, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210});
      set_word(1, 3, {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555});
      set_word(2, 3, {64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002});

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
      chk("rst_sel_err", 64'(sel_err), 64'd0);
      chk("rst_ra_out", 64'(|ra_out), 64'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Table: single beats, exact two-cycle latency
      for (int i = 0; i < 5; i++) begin
         bn_sel = tbl[i].sel;
         seg_lsb_first = tbl[i].lsb;
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk("lat_not_early", 64'(out_valid), 64'd0);
         @(posedge clk);
         #1;
         chk("lat_valid", 64'(out_valid), 64'd1);
         chk("tbl_lane6", ra_out[6*PW +: PW], tbl[i].e6);
         chk("tbl_lane7", ra_out[7*PW +: PW], tbl[i].e7);
      end
      drain();

      // 10 back-to-back beats under a 1,0,0 out_ready pattern
      n_hs = 0;
      or_mode = 2;
      for (int j = 0; j < 10; j++) begin
         for (int m = 0; m < int'(MN); m++)
            set_word(j % 3, m, {32'(j), 32'(m), 64'(j * 16 + m)});
         send(2'(j % 3), 1'(j & 1));
      end
      drain();
      chk("toggle_beats_out", 64'(n_hs), 64'd10);

      // Frame counting: 9 continuous beats after reset
      do_reset();
      cnt_log.delete();
      last_log.delete();
      n_last = 0;
      randomize_mem();
      for (int j = 0; j < 9; j++) send(2'(j % 2), 1'b0);
      drain();
      chk("frame_beats", 64'(cnt_log.size()), 64'd9);
      for (int j = 0; j < int'(cnt_log.size()); j++) begin
         chk("frame_cnt_seq", 64'(cnt_log[j]), 64'(j % 4));
         chk("frame_last_seq", 64'(last_log[j]), 64'(j % 4 == 3));
      end
      chk("frame_n_last", 64'(n_last), 64'd2);

      // Illegal select on beat 2 of 4
      do_reset();
      for (int j = 0; j < 4; j++) begin
         if (j == 2) chk("err_before_bad", 64'(sel_err), 64'd0);
         send((j == 2) ? 2'd3 : 2'(j % 3), 1'b0);
         if (j == 2) chk("err_at_bad", 64'(sel_err), 64'd1);
      end
      drain();
      chk("err_sticky", 64'(sel_err), 64'd1);

      // Mid-stream reset with two beats in flight
      send(2'd1, 1'b0);
      drain();
      chk("pre_rst_cnt", 64'(beat_cnt), 64'd1);
      or_mode = 1;
      @(posedge clk);
      #1;
      send(2'd0, 1'b0);
      send(2'd1, 1'b1);
      chk("full_stall_ready", 64'(in_ready), 64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_cnt", 64'(beat_cnt), 64'd0);
      chk("mid_rst_err", 64'(sel_err), 64'd0);
      chk("mid_rst_last", 64'(out_last), 64'd0);
      chk("mid_rst_ra_out", 64'(|ra_out), 64'd0);
      rst = 1'b0;
      #1;
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      or_mode = 0;

      // Randomized traffic
      or_mode = 3;
      for (int c = 0; c < 400; c++) begin
         randomize_mem();
         bn_sel = 2'($urandom_range(0, 3));
         seg_lsb_first = 1'($urandom_range(0, 1));
         in_valid = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bn_unpack_mux_pipe.md
Name: bn_unpack_mux_pipe

Overview:
- Parametrised, pipelined successor of the two-bank radix-16 operand mux.
- Selects one of BN_NUM memory banks, each with MEM_NUM words of SD_WIDTH bits. Unpacks each word into PACK points of P_WIDTH bits, giving RADIX = MEM_NUM*PACK butterfly lanes.
- Sits between the bank memories and the radix-R butterfly.
- Adds valid/ready flow control, a selectable segment order, frame beat counting and an illegal-select flag.

Parameters:
- P_WIDTH, 64, bits per point.
- PACK, 2, points packed per memory word; SD_WIDTH = P_WIDTH*PACK (localparam).
- MEM_NUM, 8, memories per bank.
- BN_NUM, 2, number of banks (≥1); SEL_W = max(1, clog2(BN_NUM)) (localparam).
- FRAME_LEN, 1024, output beats per frame (≥2); CNT_W = clog2(FRAME_LEN) (localparam).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- bn_mem_in  in  BN_NUM*MEM_NUM*SD_WIDTH  bank b, memory m word at [(b*MEM_NUM+m)*SD_WIDTH +: SD_WIDTH].
- bn_sel  in  SEL_W  bank select, sampled with in_valid.
- seg_lsb_first  in  1  segment-order mode, sampled with in_valid.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat.
- ra_out  out  RADIX*P_WIDTH  lane i at [i*P_WIDTH +: P_WIDTH].
- out_valid  out  1  ra_out valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  high on the final beat of a frame.
- beat_cnt  out  CNT_W  index of the current output beat within its frame.
- sel_err  out  1  sticky: an out-of-range bn_sel was accepted.

Behaviour:
- Input accept: in_valid & in_ready. Output handshake: out_valid & out_ready.
- Pipeline stage S1 registers the selected bank's MEM_NUM words plus the mode bit and a zero flag. Stage S2 registers the unpacked lanes.
- Advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. The combinational path out_ready→in_ready is permitted.
- Latency: accepted beat appears on ra_out exactly 2 cycles later when out_ready is held high. Throughput 1 beat/cycle. No beat is dropped or duplicated under any out_ready pattern.
- Data is held stable while out_valid & !out_ready.
- Unpack rule, word w from memory m, k = 0..PACK-1:
  - seg_lsb_first=0: lane m*PACK+k = w[SD_WIDTH-1-k*P_WIDTH -: P_WIDTH]. The MSB segment goes to the even lane, matching the legacy mapping.
  - seg_lsb_first=1: lane m*PACK+k = w[k*P_WIDTH +: P_WIDTH].
- Illegal select: if bn_sel ≥ BN_NUM at accept, that beat's lanes are all zero and sel_err sets to 1. sel_err clears only on rst. The beat is still counted.
- Beat counter:
  - beat_cnt increments on each output handshake and wraps FRAME_LEN-1 → 0.
  - out_last = out_valid & (beat_cnt == FRAME_LEN-1).
- Reset, including mid-stream: next edge forces s1_valid=0, out_valid=0, ra_out=0, beat_cnt=0, out_last=0, sel_err=0. In-flight beats are discarded.
- in_ready is 1 in the cycle after reset deasserts.
- While rst is high, in_ready=0 and inputs are ignored.
- Simultaneous accept and output handshake in the same cycle is legal and sustains full rate.

Test Plan:
- Defaults, bn_sel=1, seg_lsb_first=0, out_ready=1, BN1 MEM3 = 128'hAAAA..._5555...: on the 2nd edge after accept, out_valid=1, lane6=64'hAAAA..., lane7=64'h5555.... Repeat with bn_sel=0 to check BN0.
- Same beat with seg_lsb_first=1: lane6=64'h5555..., lane7=64'hAAAA....
- 10 back-to-back beats with incrementing data; out_ready toggles 1,0,0,1,... for 20 cycles. Required: all 10 beats out in order, no duplicates, data held while stalled, in_ready low only when both stages are full and stalled.
- FRAME_LEN=4, 9 continuous beats: beat_cnt sequence 0,1,2,3,0,1,2,3,0; out_last high on beats 4 and 8 only.
- BN_NUM=3, bn_sel=3 on beat 2 of 4: beat 2 lanes all zero, sel_err rises at its accept and stays 1; other beats are correct.
- Assert rst for one cycle with 2 beats in flight: next cycle out_valid=0, beat_cnt=0, sel_err=0, and in_ready=1 after reset drops.
